if_pc_gen: RTL and testbench

Fetch-side PC generator: owns the IF-stage program counter and is the receiving end of the EX-stage branch redirect. It selects the next fetch PC from redirect, stall, predicted-taken target or sequential PC+4, and raises the IF/ID kill on redirect. It holds a small direct-mapped branch predictor (2-bit counters plus target buffer) trained from resolved EX branches. The `predict`/`predict_target` outputs travel down the pipeline with the instruction so EX can detect mispredictions.

---
 rtl/if_pc_gen_if.sv | 30 +++
 rtl/if_pc_gen.sv | 135 +++++++++++++
 tb/tb_if_pc_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_pc_gen_if.sv
// if_pc_gen_if: fetch-PC generator bus. Carries the hazard stall, the EX
// redirect and training inputs, and the fetch PC and prediction outputs.
// The slave modport is the PC generator. The master modport is the pipeline
// side that drives it.
interface if_pc_gen_if;
  logic        stall;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_update_valid;
  logic [31:0] ex_update_pc;
  logic        ex_update_taken;
  logic [31:0] ex_update_target;
  logic [31:0] pc_if;
  logic        pc_valid;
  logic        predict;
  logic [31:0] predict_target;
  logic        flush_if_id;

  modport master (
    output stall, ex_redirect, ex_redirect_pc,
    output ex_update_valid, ex_update_pc, ex_update_taken, ex_update_target,
    input  pc_if, pc_valid, predict, predict_target, flush_if_id
  );

  modport slave (
    input  stall, ex_redirect, ex_redirect_pc,
    input  ex_update_valid, ex_update_pc, ex_update_taken, ex_update_target,
    output pc_if, pc_valid, predict, predict_target, flush_if_id
  );
endinterface

// File: rtl/if_pc_gen.sv
// if_pc_gen: IF-stage program counter.
// The next PC is chosen in this priority: EX redirect, then stall (hold),
// then the predicted target, then PC+4.
// The IF/ID flush follows ex_redirect in the same cycle.
// Optional macro IF_BHT_EN builds a direct-mapped predictor. Each entry holds
// a valid bit, a 2-bit counter, a tag and a target. EX branch resolution
// trains it. Without the macro the design is a plain sequential fetch PC.

`ifdef IF_BHT_EN
// One predictor entry: valid, tag, 2-bit saturating counter and target.
module if_pc_gen_entry #(
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             taken,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_tgt,
  output logic             vld,
  output logic [1:0]       cnt,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      tgt
);
  logic hit;
  assign hit = vld && (tag == wr_tag);

  // Train on a resolved branch. A taken miss allocates the entry weakly
  // taken. A not-taken miss leaves the entry alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      cnt <= 2'b01;
      tag <= '0;
      tgt <= '0;
    end else if (wr) begin
      if (taken) begin
        tgt <= wr_tgt;
        if (hit) begin
          cnt <= (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
          vld <= 1'b1;
          tag <= wr_tag;
          cnt <= 2'b10;
        end
      end else if (hit) begin
        cnt <= (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
      end
    end
  end
endmodule
`endif

module if_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h1C00_0000,
  parameter int          BHT_IDX_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  if_pc_gen_if.slave   bus
);
  logic [31:0] pc_q;
  logic        pc_vld_q;
  logic [31:0] seq_pc;
  logic        pred;
  logic [31:0] pred_tgt;

  assign seq_pc = pc_q + 32'd4;

`ifdef IF_BHT_EN
  localparam int ENTRIES = 1 << BHT_IDX_W;
  localparam int TAG_W   = 30 - BHT_IDX_W;

  logic [ENTRIES-1:0]            e_vld;
  logic [ENTRIES-1:0][1:0]       e_cnt;
  logic [ENTRIES-1:0][TAG_W-1:0] e_tag;
  logic [ENTRIES-1:0][31:0]      e_tgt;

  logic [BHT_IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag, up_tag;

  assign lk_idx = pc_q[BHT_IDX_W+1:2];
  assign lk_tag = pc_q[31:BHT_IDX_W+2];
  assign up_idx = bus.ex_update_pc[BHT_IDX_W+1:2];
  assign up_tag = bus.ex_update_pc[31:BHT_IDX_W+2];

  // Entries update only on the clock edge. The combinational lookup below
  // therefore reads the pre-update entry when it shares an index with a
  // same-cycle update.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    if_pc_gen_entry #(.TAG_W(TAG_W)) u_ent (
      .clk    (clk),
      .rst    (rst),
      .wr     (bus.ex_update_valid && (up_idx == BHT_IDX_W'(i))),
      .taken  (bus.ex_update_taken),
      .wr_tag (up_tag),
      .wr_tgt (bus.ex_update_target),
      .vld    (e_vld[i]),
      .cnt    (e_cnt[i]),
      .tag    (e_tag[i]),
      .tgt    (e_tgt[i])
    );
  end

  assign pred     = e_vld[lk_idx] && (e_tag[lk_idx] == lk_tag) && (e_cnt[lk_idx] >= 2'b10);
  assign pred_tgt = pred ? e_tgt[lk_idx] : seq_pc;
`else
  logic unused_upd;
  assign unused_upd = ^{bus.ex_update_valid, bus.ex_update_pc,
                        bus.ex_update_taken, bus.ex_update_target};
  assign pred     = 1'b0;
  assign pred_tgt = seq_pc;
`endif

  // Fetch PC register. The first cycle after reset only raises pc_valid.
  // pred_tgt already folds together the predicted target and PC+4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pc_vld_q <= 1'b0;
    end else begin
      pc_vld_q <= 1'b1;
      if (pc_vld_q) begin
        if (bus.ex_redirect)  pc_q <= bus.ex_redirect_pc;
        else if (!bus.stall)  pc_q <= pred_tgt;
      end
    end
  end

  assign bus.pc_if          = pc_q;
  assign bus.pc_valid       = pc_vld_q;
  assign bus.predict        = pred;
  assign bus.predict_target = pred_tgt;
  assign bus.flush_if_id    = bus.ex_redirect;
endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: a directed vector table from the bring-up sequence,
// then randomized traffic and a mid-run asynchronous reset. Every cycle is
// checked against a table-level reference model.
module tb_if_pc_gen;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam int IDX_W = 6;
  localparam int N     = 1 << IDX_W;
`ifdef IF_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  if_pc_gen_if bus();

  if_pc_gen #(.RESET_PC(RST_PC), .BHT_IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_val;
  bit          m_v   [N];
  int          m_cnt [N];
  int unsigned m_tag [N];
  logic [31:0] m_tgt [N];
  bit          m_pred;
  logic [31:0] m_ptgt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc >> (IDX_W + 2));
  endfunction

  task automatic model_reset();
    m_pc  = RST_PC;
    m_val = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = '0;
    end
  endtask

  task automatic model_lookup();
    int i;
    i = idx_of(m_pc);
    m_pred = BHT && m_v[i] && (m_tag[i] == tag_of(m_pc)) && (m_cnt[i] >= 2);
    m_ptgt = m_pred ? m_tgt[i] : m_pc + 32'd4;
  endtask

  // Advance the model by one clock edge, using the inputs sampled before it.
  task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit uv, input logic [31:0] upc, input bit ut,
                            input logic [31:0] utg);
    int i;
    bit hit;
    if (m_val) begin
      if (rd)          m_pc = rpc;
      else if (!st)    m_pc = m_ptgt;
    end
    m_val = 1'b1;
    if (BHT && uv) begin
      i = idx_of(upc);
      hit = m_v[i] && (m_tag[i] == tag_of(upc));
      if (ut) begin
        m_tgt[i] = utg;
        if (hit) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        else begin m_v[i] = 1'b1; m_tag[i] = tag_of(upc); m_cnt[i] = 2; end
      end else if (hit) begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end
  endtask

  task automatic drive(input bit st, input bit rd, input logic [31:0] rpc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg);
    bus.stall = st; bus.ex_redirect = rd; bus.ex_redirect_pc = rpc;
    bus.ex_update_valid = uv; bus.ex_update_pc = upc;
    bus.ex_update_taken = ut; bus.ex_update_target = utg;
  endtask

  // One cycle: inputs are already driven at the falling edge. Compare the
  // outputs mid-phase, then take the rising edge and step the model.
  task automatic cycle();
    #1;
    model_lookup();
    chk("pc_if",          bus.pc_if,          m_pc);
    chk("pc_valid",       32'(bus.pc_valid),  32'(m_val));
    chk("predict",        32'(bus.predict),   32'(m_pred));
    chk("predict_target", bus.predict_target, m_ptgt);
    chk("flush_if_id",    32'(bus.flush_if_id), 32'(bus.ex_redirect));
    @(posedge clk);
    model_edge(bus.stall, bus.ex_redirect, bus.ex_redirect_pc, bus.ex_update_valid,
               bus.ex_update_pc, bus.ex_update_taken, bus.ex_update_target);
    @(negedge clk);
  endtask

  typedef struct {
    bit          st, rd;
    logic [31:0] rpc;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
    logic [31:0] pc_b;  bit pred_b;
    logic [31:0] pc_n;  bit pred_n;
  } vec_t;

  function automatic vec_t v(input bit st, input bit rd, input logic [31:0] rpc,
                             input bit uv, input logic [31:0] upc, input bit ut,
                             input logic [31:0] utg, input logic [31:0] pc_b,
                             input bit pred_b, input logic [31:0] pc_n, input bit pred_n);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.uv = uv; r.upc = upc; r.ut = ut; r.utg = utg;
    r.pc_b = pc_b; r.pred_b = pred_b; r.pc_n = pc_n; r.pred_n = pred_n;
    return r;
  endfunction

  vec_t tbl[22];

  initial begin
    logic [31:0] B, T, A;
    B = 32'h1C00_0020; T = 32'h1C00_0080; A = 32'h1C00_0120;
    //            st rd rpc           uv upc ut utg  pc(bht)       pr  pc(no bht)    pr
    tbl[0]  = v(0, 0, 0,             0, 0, 0, 0,  32'h1C00_0000, 0, 32'h1C00_0000, 0);
    tbl[1]  = v(0, 0, 0,             0, 0, 0, 0,  32'h1C00_0000, 0, 32'h1C00_0000, 0);
    tbl[2]  = v(0, 0, 0,             0, 0, 0, 0,  32'h1C00_0004, 0, 32'h1C00_0004, 0);
    tbl[3]  = v(0, 0, 0,             0, 0, 0, 0,  32'h1C00_0008, 0, 32'h1C00_0008, 0);
    tbl[4]  = v(0, 0, 0,             0, 0, 0, 0,  32'h1C00_000C, 0, 32'h1C00_000C, 0);
    tbl[5]  = v(1, 0, 0,             0, 0, 0, 0,  32'h1C00_0010, 0, 32'h1C00_0010, 0);
    tbl[6]  = v(1, 0, 0,             0, 0, 0, 0,  32'h1C00_0010, 0, 32'h1C00_0010, 0);
    tbl[7]  = v(1, 0, 0,             0, 0, 0, 0,  32'h1C00_0010, 0, 32'h1C00_0010, 0);
    tbl[8]  = v(1, 1, 32'h1C00_0100, 0, 0, 0, 0,  32'h1C00_0010, 0, 32'h1C00_0010, 0);
    tbl[9]  = v(0, 0, 0,             1, B, 1, T,  32'h1C00_0100, 0, 32'h1C00_0100, 0);
    tbl[10] = v(0, 1, B,             0, 0, 0, 0,  32'h1C00_0104, 0, 32'h1C00_0104, 0);
    tbl[11] = v(0, 0, 0,             0, 0, 0, 0,  B,             1, B,             0);
    tbl[12] = v(0, 0, 0,             1, B, 0, 0,  T,             0, 32'h1C00_0024, 0);
    tbl[13] = v(0, 1, B,             1, B, 0, 0,  32'h1C00_0084, 0, 32'h1C00_0028, 0);
    tbl[14] = v(0, 0, 0,             0, 0, 0, 0,  B,             0, B,             0);
    tbl[15] = v(0, 0, 0,             1, B, 1, T,  32'h1C00_0024, 0, 32'h1C00_0024, 0);
    tbl[16] = v(0, 1, A,             1, B, 1, T,  32'h1C00_0028, 0, 32'h1C00_0028, 0);
    tbl[17] = v(0, 1, B,             0, 0, 0, 0,  A,             0, A,             0);
    tbl[18] = v(0, 0, 0,             1, B, 0, 0,  B,             1, B,             0);
    tbl[19] = v(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0,  T,             0, 32'h1C00_0024, 0);
    tbl[20] = v(0, 0, 0,             0, 0, 0, 0,  32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0);
    tbl[21] = v(0, 0, 0,             0, 0, 0, 0,  32'h0000_0000, 0, 32'h0000_0000, 0);
  end

  initial begin
    drive(0, 0, '0, 0, '0, 0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset pc_if",    bus.pc_if, RST_PC);
    chk("reset pc_valid", 32'(bus.pc_valid), 32'd0);
    chk("reset predict",  32'(bus.predict), 32'd0);
    chk("reset flush",    32'(bus.flush_if_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed bring-up sequence
    for (int k = 0; k < 22; k++) begin
      drive(tbl[k].st, tbl[k].rd, tbl[k].rpc, tbl[k].uv, tbl[k].upc, tbl[k].ut, tbl[k].utg);
      #1;
      chk($sformatf("vec%0d pc_if", k), bus.pc_if, BHT ? tbl[k].pc_b : tbl[k].pc_n);
      chk($sformatf("vec%0d predict", k), 32'(bus.predict),
          32'(BHT ? tbl[k].pred_b : tbl[k].pred_n));
      #1;
      chk($sformatf("vec%0d flush", k), 32'(bus.flush_if_id), 32'(tbl[k].rd));
      #(-2 + 2);
      // The cycle task adds its own 1-unit settle delay. The cycle still
      // finishes at the next falling edge.
      cycle();
    end

    // Randomized traffic, with an asynchronous reset in the middle
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        #2 rst = 1'b1;
        #1;
        chk("async rst pc_if",    bus.pc_if, RST_PC);
        chk("async rst pc_valid", 32'(bus.pc_valid), 32'd0);
        chk("async rst predict",  32'(bus.predict), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            (($urandom_range(0, 31) == 0) ? 32'hFFFF_FF00 : 32'h1C00_0000)
              + ($urandom_range(0, 255) << 2),
            $urandom_range(0, 1) == 1,
            32'h1C00_0000 + ($urandom_range(0, 255) << 2),
            $urandom_range(0, 2) != 0,
            32'h1C00_0000 + ($urandom_range(0, 255) << 2));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the stimulus has a fixed length, so this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
